// File: rtl/vga_frame_engine.sv
// rtl/vga_frame_engine.sv - parametrised VGA timing, registered colour/sync output and tear-free object shadow
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   obj_wr_i               strobe: capture obj_x_in_i/obj_y_in_i into the pending shadow
//   obj_x_in_i, obj_y_in_i new object position
//   rgb_in_i               colour for the pixel currently addressed by pixel_x_o/pixel_y_o
//   p_tick_o               pixel enable, one clk every CLK_DIV clks
//   pixel_x_o, pixel_y_o   raster counters of the pixel being fetched
//   video_on_o             fetched pixel lies in the visible area
//   frame_start_o          p_tick at pixel (0,0)
//   obj_x_o, obj_y_o       committed object position, constant for a whole frame
//   rgb_o, hsync_o, vsync_o registered DAC outputs, one pixel behind the counters
module vga_frame_engine #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   RGB_W    = 12,
    parameter int   COORD_W  = 10,
    parameter int   OBJ_X0   = 10,
    parameter int   OBJ_Y0   = 300
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               obj_wr_i,
    input  logic [COORD_W-1:0] obj_x_in_i,
    input  logic [COORD_W-1:0] obj_y_in_i,
    input  logic [RGB_W-1:0]   rgb_in_i,
    output logic               p_tick_o,
    output logic [COORD_W-1:0] pixel_x_o,
    output logic [COORD_W-1:0] pixel_y_o,
    output logic               video_on_o,
    output logic               frame_start_o,
    output logic [COORD_W-1:0] obj_x_o,
    output logic [COORD_W-1:0] obj_y_o,
    output logic [RGB_W-1:0]   rgb_o,
    output logic               hsync_o,
    output logic               vsync_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic [COORD_W-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
    logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic               pending_q, pending_d;

    logic p_tick, line_end, frame_end, video_on, commit;

    always_comb begin
        p_tick    = (div_q == DIV_LAST);
        line_end  = (x_q == H_LAST);
        frame_end = line_end && (y_q == V_LAST);
        video_on  = (x_q < H_ACT) && (y_q < V_ACT);
        // Commit only on the very last pixel tick so the new position appears exactly at frame_start.
        commit    = p_tick && frame_end && pending_q;

        div_d     = p_tick ? '0 : div_q + 1'b1;
        x_d       = x_q;
        y_d       = y_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        if (p_tick) begin
            x_d   = line_end ? '0 : x_q + 1'b1;
            if (line_end) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end
            rgb_d = video_on ? rgb_in_i : '0;
            hs_d  = ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) ? HS_POL : ~HS_POL;
            vs_d  = ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) ? VS_POL : ~VS_POL;
        end

        obj_x_d   = commit ? pend_x_q : obj_x_q;
        obj_y_d   = commit ? pend_y_q : obj_y_q;
        // A write landing on the commit edge is kept for the next frame; the commit uses the older value.
        pend_x_d  = obj_wr_i ? obj_x_in_i : pend_x_q;
        pend_y_d  = obj_wr_i ? obj_y_in_i : pend_y_q;
        pending_d = obj_wr_i || (pending_q && !commit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            obj_x_q   <= COORD_W'(OBJ_X0);
            obj_y_q   <= COORD_W'(OBJ_Y0);
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            obj_x_q   <= obj_x_d;
            obj_y_q   <= obj_y_d;
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            pending_q <= pending_d;
        end
    end

    assign p_tick_o      = p_tick;
    assign pixel_x_o     = x_q;
    assign pixel_y_o     = y_q;
    assign video_on_o    = video_on;
    assign frame_start_o = p_tick && (x_q == '0) && (y_q == '0);
    assign obj_x_o       = obj_x_q;
    assign obj_y_o       = obj_y_q;
    assign rgb_o         = rgb_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
endmodule
